// File: rtl/z80_bus_sequencer_pkg.sv
// z80_bus_pkg: shared types and constants for the Z80 bus sequencer.
//   seq_state_e  - bus-cycle FSM states
//   strobes_t    - packed view of the five active-low Z80 strobes
//   SYNC_STAGES  - synchroniser depth on the strobe inputs
//   ABORT_CNT_W  - width of the saturating abort counter
package z80_bus_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int STROBE_W    = 5;
  localparam int ABORT_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    DRIVE    = 3'd3,
    DONE     = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic m1_n;
    logic iorq_n;
    logic mrq_n;
    logic wr_n;
    logic rd_n;
  } strobes_t;

  function automatic logic [ABORT_CNT_W-1:0] sat_inc(input logic [ABORT_CNT_W-1:0] v);
    logic [ABORT_CNT_W-1:0] one;
    one = {{(ABORT_CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

endpackage

// File: rtl/z80_bus_sequencer_if.sv
// z80_bus_sequencer_if: request/response channel between the Z80 bus
// sequencer (master) and the backend slaves (ROM, LED/IO ports).
//   req_valid/req_ready - one handshake per claimed bus cycle
//   req_write, req_io   - cycle type
//   req_addr, req_wdata - address and write data latched at cycle start
//   rsp_valid/rsp_rdata - read data returned by the backend (reads only)
interface z80_bus_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;

  modport master (
    output req_valid, req_write, req_io, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_io, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/z80_bus_sequencer_sync.sv
// z80_sync2: multi-bit flop-chain synchroniser (SYNC_STAGES deep) for
// asynchronous level inputs. Each bit is synchronised independently.
//   clk  - destination clock
//   rst  - synchronous active-high reset, loads RESET_VAL into every stage
//   din  - asynchronous inputs
//   dout - synchronised outputs
module z80_sync2
  import z80_bus_pkg::*;
#(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/z80_bus_sequencer.sv
// z80_bus_sequencer: RC2014 bus front end. Synchronises the Z80 strobes,
// classifies each bus cycle, issues one backend request per claimed cycle
// and drives read data back onto the data pads.
//
// Ports:
//   CLK, RST            - system clock, synchronous active-high reset
//   A, D_IN             - raw Z80 address and sampled data bus
//   RD, WR, MRQ, IORQ, M1 - asynchronous active-low Z80 strobes
//   D_OUT, D_OE         - read data and pad output enable
//   WAIT                - active-low Z80 wait (only with Z80_WAIT_EN)
//   be                  - backend request/response channel (master side)
//   abort_cnt           - saturating count of aborted cycles
//
// Build option: define Z80_WAIT_EN to add the WAIT output, which stalls the
// CPU while a request or response is outstanding.
//
// State     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a new bus cycle to start
// REQ       | request presented to backend, waiting for req_ready
// WAIT_RSP  | read accepted, waiting for rsp_valid
// DRIVE     | driving read data onto D until RD deasserts
// DONE      | cycle finished or unclaimed, waiting for RD and WR high
module z80_bus_sequencer
  import z80_bus_pkg::*;
#(
  parameter logic [15:0] MEM_BASE = 16'h0000,
  parameter logic [15:0] MEM_SIZE = 16'h2000,
  parameter logic [7:0]  IO_BASE  = 8'hC0,
  parameter logic [7:0]  IO_SIZE  = 8'h04
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [15:0]            A,
  input  logic [7:0]             D_IN,
  input  logic                   RD,
  input  logic                   WR,
  input  logic                   MRQ,
  input  logic                   IORQ,
  input  logic                   M1,
  output logic [7:0]             D_OUT,
  output logic                   D_OE,
`ifdef Z80_WAIT_EN
  output logic                   WAIT,
`endif
  z80_bus_sequencer_if.master    be,
  output logic [ABORT_CNT_W-1:0] abort_cnt
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  strobes_t              s;
  logic [STROBE_W-1:0]   s_vec;

  seq_state_e            state_q, state_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_write_q, req_write_d;
  logic                  req_io_q, req_io_d;
  logic [15:0]           req_addr_q, req_addr_d;
  logic [7:0]            req_wdata_q, req_wdata_d;
  logic [7:0]            d_out_q, d_out_d;
  logic                  d_oe_q, d_oe_d;
  logic [ABORT_CNT_W-1:0] abort_cnt_q, abort_cnt_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic                  armed_q, armed_d;

  logic                  bus_active;
  logic                  intack;
  logic                  cycle_end;
  logic                  cycle_io;
  logic                  cycle_wr;
  logic                  settled;
  logic                  start;
  logic                  claimed;
  logic [15:0]           mem_off;
  logic [7:0]            io_off;

  z80_sync2 #(
    .WIDTH     (STROBE_W),
    .RESET_VAL ({STROBE_W{1'b1}})
  ) u_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  ({M1, IORQ, MRQ, WR, RD}),
    .dout (s_vec)
  );

  assign s = strobes_t'(s_vec);

  assign bus_active = (!s.mrq_n || !s.iorq_n) && (!s.rd_n || !s.wr_n);
  assign intack     = !s.m1_n && !s.iorq_n;
  assign cycle_end  = s.rd_n && s.wr_n;
  assign cycle_io   = !s.iorq_n && s.mrq_n;
  assign cycle_wr   = !s.wr_n;

  // Unsigned subtraction at operand width: addresses below the base wrap
  // to large offsets and fall outside the window.
  assign mem_off = A - MEM_BASE;
  assign io_off  = A[7:0] - IO_BASE;
  assign claimed = cycle_io ? (io_off < IO_SIZE) : (mem_off < MEM_SIZE);

  // The synchroniser outputs read "idle" during and just after reset, so
  // they are not trusted until the chain has refilled. Only an idle-to-active
  // transition seen after that counts as a cycle start, which keeps a cycle
  // that straddles reset release from being serviced.
  assign settled = (settle_q == SETTLE_W'(SYNC_STAGES));
  assign start   = bus_active && armed_q && !intack;

  always_comb begin
    settle_d = settled ? settle_q : settle_q + 1'b1;
    armed_d  = settled && !bus_active;
  end

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_io_d    = req_io_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    abort_cnt_d = abort_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (claimed) begin
            req_valid_d = 1'b1;
            req_write_d = cycle_wr;
            req_io_d    = cycle_io;
            req_addr_d  = A;
            req_wdata_d = D_IN;
            state_d     = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end

      REQ: begin
        // Abort wins over a simultaneous req_ready; the backend still sees
        // the handshake complete because req_valid drops either way.
        if (cycle_end) begin
          req_valid_d = 1'b0;
          abort_cnt_d = sat_inc(abort_cnt_q);
          state_d     = IDLE;
        end else if (be.req_ready) begin
          req_valid_d = 1'b0;
          state_d     = req_write_q ? DONE : WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        if (cycle_end) begin
          abort_cnt_d = sat_inc(abort_cnt_q);
          state_d     = IDLE;
        end else if (be.rsp_valid) begin
          d_out_d = be.rsp_rdata;
          d_oe_d  = 1'b1;
          state_d = DRIVE;
        end
      end

      DRIVE: begin
        if (s.rd_n) begin
          d_oe_d  = 1'b0;
          state_d = IDLE;
        end
      end

      DONE: begin
        if (cycle_end) begin
          state_d = IDLE;
        end
      end

      default: begin
        req_valid_d = 1'b0;
        d_oe_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_io_q    <= 1'b0;
      req_addr_q  <= 16'h0000;
      req_wdata_q <= 8'h00;
      d_out_q     <= 8'h00;
      d_oe_q      <= 1'b0;
      abort_cnt_q <= '0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_io_q    <= req_io_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      abort_cnt_q <= abort_cnt_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  assign be.req_valid = req_valid_q;
  assign be.req_write = req_write_q;
  assign be.req_io    = req_io_q;
  assign be.req_addr  = req_addr_q;
  assign be.req_wdata = req_wdata_q;
  assign D_OUT        = d_out_q;
  assign D_OE         = d_oe_q;
  assign abort_cnt    = abort_cnt_q;

`ifdef Z80_WAIT_EN
  // REQ and WAIT_RSP are only ever entered for claimed cycles.
  assign WAIT = !((state_q == REQ) || (state_q == WAIT_RSP));
`endif

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// tb_z80_bus_sequencer: directed table-driven bench for z80_bus_sequencer,
// plus hand sequences for aborts, counter saturation and mid-cycle reset.
module tb_z80_bus_sequencer;

  logic        CLK;
  logic        RST;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic        RD, WR, MRQ, IORQ, M1;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  abort_cnt;
`ifdef Z80_WAIT_EN
  logic        WAIT;
`endif

  z80_bus_sequencer_if bus();

  z80_bus_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .D_IN      (D_IN),
    .RD        (RD),
    .WR        (WR),
    .MRQ       (MRQ),
    .IORQ      (IORQ),
    .M1        (M1),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
`ifdef Z80_WAIT_EN
    .WAIT      (WAIT),
`endif
    .be        (bus),
    .abort_cnt (abort_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        io;
    logic        wr;
    logic        m1_n;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        exp_req;
    logic        exp_write;
    logic        exp_io;
    logic        exp_oe;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic bus_release();
    RD = 1'b1; WR = 1'b1; MRQ = 1'b1; IORQ = 1'b1; M1 = 1'b1;
  endtask

  // One full Z80 cycle: strobes fall, request handshake (if any), read
  // response 2 CLK after acceptance, then strobes rise.
  task automatic do_cycle(input vec_t v, input string tag);
    bit seen;
    int lat;
    @(negedge CLK);
    A = v.addr; D_IN = v.wdata; M1 = v.m1_n;
    if (v.io) IORQ = 1'b0; else MRQ = 1'b0;
    if (v.wr) WR = 1'b0; else RD = 1'b0;
    seen = 1'b0; lat = 0;
    while (!seen && lat < 8) begin
      @(negedge CLK);
      lat++;
      if (bus.req_valid) seen = 1'b1;
    end
    check({tag, ".req_seen"}, seen, v.exp_req);
    if (seen) begin
      check({tag, ".latency"}, lat, 3);
      check({tag, ".req_write"}, bus.req_write, v.exp_write);
      check({tag, ".req_io"}, bus.req_io, v.exp_io);
      check({tag, ".req_addr"}, bus.req_addr, v.addr);
      check({tag, ".req_wdata"}, bus.req_wdata, v.wdata);
      repeat (2) @(negedge CLK);
      check({tag, ".valid_hold"}, {bus.req_valid, bus.req_addr}, {1'b1, v.addr});
      bus.req_ready = 1'b1;
      @(negedge CLK);
      bus.req_ready = 1'b0;
      check({tag, ".valid_drop"}, bus.req_valid, 1'b0);
      if (!v.wr) begin
        @(negedge CLK);
        bus.rsp_valid = 1'b1; bus.rsp_rdata = v.rdata;
        @(negedge CLK);
        bus.rsp_valid = 1'b0; bus.rsp_rdata = 8'h00;
        check({tag, ".oe_rise"}, D_OE, 1'b1);
      end
    end
    repeat (2) @(negedge CLK);
    check({tag, ".oe"}, D_OE, v.exp_oe);
    if (v.exp_oe) check({tag, ".d_out"}, D_OUT, v.rdata);
    bus_release();
    if (v.exp_oe) begin
      repeat (2) @(negedge CLK);
      check({tag, ".oe_hold"}, D_OE, 1'b1);
      @(negedge CLK);
      check({tag, ".oe_fall"}, D_OE, 1'b0);
    end
    repeat (4) @(negedge CLK);
    check({tag, ".idle_out"}, {bus.req_valid, D_OE}, 2'b00);
  endtask

  // Memory read at 0x0100 that ends before completing; optionally the
  // request is accepted first so the abort happens in WAIT_RSP.
  task automatic abort_cycle(input bit accept, output bit seen);
    int n;
    @(negedge CLK);
    A = 16'h0100; D_IN = 8'h00; MRQ = 1'b0; RD = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 8) begin
      @(negedge CLK);
      n++;
      if (bus.req_valid) seen = 1'b1;
    end
    if (accept && seen) begin
      bus.req_ready = 1'b1;
      @(negedge CLK);
      bus.req_ready = 1'b0;
    end
    repeat (2) @(negedge CLK);
    bus_release();
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int misses;
    bit req_during;

    vecs[0]  = '{io:1'b0, wr:1'b0, m1_n:1'b1, addr:16'h0010, wdata:8'hEE, rdata:8'h3E, exp_req:1'b1, exp_write:1'b0, exp_io:1'b0, exp_oe:1'b1};
    vecs[1]  = '{io:1'b1, wr:1'b1, m1_n:1'b1, addr:16'h00C1, wdata:8'h55, rdata:8'h00, exp_req:1'b1, exp_write:1'b1, exp_io:1'b1, exp_oe:1'b0};
    vecs[2]  = '{io:1'b0, wr:1'b0, m1_n:1'b1, addr:16'h8000, wdata:8'h00, rdata:8'h00, exp_req:1'b0, exp_write:1'b0, exp_io:1'b0, exp_oe:1'b0};
    vecs[3]  = '{io:1'b1, wr:1'b0, m1_n:1'b0, addr:16'h00C0, wdata:8'h00, rdata:8'h00, exp_req:1'b0, exp_write:1'b0, exp_io:1'b0, exp_oe:1'b0};
    vecs[4]  = '{io:1'b0, wr:1'b1, m1_n:1'b1, addr:16'h1FFF, wdata:8'hA5, rdata:8'h00, exp_req:1'b1, exp_write:1'b1, exp_io:1'b0, exp_oe:1'b0};
    vecs[5]  = '{io:1'b0, wr:1'b0, m1_n:1'b1, addr:16'h2000, wdata:8'h00, rdata:8'h00, exp_req:1'b0, exp_write:1'b0, exp_io:1'b0, exp_oe:1'b0};
    vecs[6]  = '{io:1'b1, wr:1'b0, m1_n:1'b1, addr:16'h00C3, wdata:8'h11, rdata:8'h7B, exp_req:1'b1, exp_write:1'b0, exp_io:1'b1, exp_oe:1'b1};
    vecs[7]  = '{io:1'b1, wr:1'b1, m1_n:1'b1, addr:16'h00C4, wdata:8'h22, rdata:8'h00, exp_req:1'b0, exp_write:1'b0, exp_io:1'b0, exp_oe:1'b0};
    vecs[8]  = '{io:1'b1, wr:1'b0, m1_n:1'b1, addr:16'h00BF, wdata:8'h00, rdata:8'h00, exp_req:1'b0, exp_write:1'b0, exp_io:1'b0, exp_oe:1'b0};
    vecs[9]  = '{io:1'b1, wr:1'b0, m1_n:1'b1, addr:16'h12C2, wdata:8'h33, rdata:8'h81, exp_req:1'b1, exp_write:1'b0, exp_io:1'b1, exp_oe:1'b1};
    vecs[10] = '{io:1'b0, wr:1'b0, m1_n:1'b1, addr:16'h0000, wdata:8'h44, rdata:8'hF0, exp_req:1'b1, exp_write:1'b0, exp_io:1'b0, exp_oe:1'b1};
    vecs[11] = '{io:1'b0, wr:1'b1, m1_n:1'b1, addr:16'hFFFF, wdata:8'h66, rdata:8'h00, exp_req:1'b0, exp_write:1'b0, exp_io:1'b0, exp_oe:1'b0};

    RST = 1'b1;
    A = 16'h0000; D_IN = 8'h00;
    bus_release();
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = 8'h00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    check("rst.d_oe", D_OE, 1'b0);
    check("rst.d_out", D_OUT, 8'h00);
    check("rst.req_valid", bus.req_valid, 1'b0);
    check("rst.req_write_io", {bus.req_write, bus.req_io}, 2'b00);
    check("rst.req_addr", bus.req_addr, 16'h0000);
    check("rst.req_wdata", bus.req_wdata, 8'h00);
    check("rst.abort_cnt", abort_cnt, 8'h00);
`ifdef Z80_WAIT_EN
    check("rst.wait", WAIT, 1'b1);
`endif
    repeat (5) @(negedge CLK);

    for (int i = 0; i < NVEC; i++) begin
      do_cycle(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort while the request is pending.
    abort_cycle(1'b0, seen);
    check("abort_req.seen", seen, 1'b1);
    check("abort_req.valid", bus.req_valid, 1'b0);
    check("abort_req.cnt", abort_cnt, 8'h01);

    // Late response after the abort must be dropped.
    bus.rsp_valid = 1'b1; bus.rsp_rdata = 8'h99;
    @(negedge CLK);
    bus.rsp_valid = 1'b0; bus.rsp_rdata = 8'h00;
    @(negedge CLK);
    check("late_rsp.oe", D_OE, 1'b0);
    check("late_rsp.d_out", D_OUT == 8'h99, 1'b0);

    // Abort while waiting for read data.
    abort_cycle(1'b1, seen);
    check("abort_rsp.seen", seen, 1'b1);
    check("abort_rsp.cnt", abort_cnt, 8'h02);
    check("abort_rsp.oe", D_OE, 1'b0);

    misses = 0;
    for (int i = 0; i < 256; i++) begin
      abort_cycle(1'b0, seen);
      if (!seen) misses++;
    end
    check("abort_loop.misses", misses, 0);
    check("abort_loop.sat", abort_cnt, 8'hFF);

    // Reset pulsed while driving read data.
    @(negedge CLK);
    A = 16'h0010; D_IN = 8'h00; MRQ = 1'b0; RD = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (bus.req_valid) seen = 1'b1;
      if (seen) break;
    end
    check("rst_drive.req_seen", seen, 1'b1);
    bus.req_ready = 1'b1;
    @(negedge CLK);
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1; bus.rsp_rdata = 8'h5A;
    @(negedge CLK);
    bus.rsp_valid = 1'b0;
    check("rst_drive.oe_before", {D_OE, D_OUT}, {1'b1, 8'h5A});
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_drive.oe_after", D_OE, 1'b0);
    check("rst_drive.cnt_after", abort_cnt, 8'h00);
    req_during = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (bus.req_valid || D_OE) req_during = 1'b1;
    end
    check("rst_drive.no_new_req", req_during, 1'b0);
    bus_release();
    repeat (5) @(negedge CLK);

    do_cycle(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
